// File: rtl/leading_bit_scanner.sv
// Multi-cycle leading-one / leading-zero scanner for the ALU (CLZ, CLO, MSB lookup).
// The operand is scanned from the top, CHUNK bits per cycle, stopping at the first hit.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an operand; accept latches the searched word
// SCAN  | examine one chunk per cycle, MSB chunk first
// DONE  | result held on out_* until the consumer takes it
module leading_bit_scanner #(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int IDXW   = $clog2(WIDTH),
    localparam int NCHUNK = WIDTH / CHUNK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic            in_ones,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_found,
    output logic [IDXW-1:0] out_index,
    output logic [IDXW:0]   out_count
);

    localparam int PTRW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int POSW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    localparam logic [PTRW-1:0] PTR_TOP = PTRW'(NCHUNK - 1);
    localparam logic [IDXW:0]   CNT_TOP = (IDXW + 1)'(WIDTH - 1);
    localparam logic [IDXW:0]   CNT_ALL = (IDXW + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] s_word;
    logic [PTRW-1:0] ptr;

    int              chunk_base;
    logic [CHUNK-1:0] chunk;
    logic            chunk_hit;
    logic [POSW-1:0] chunk_pos;
    logic [IDXW-1:0] hit_index;

    // Current chunk and the position of its highest set bit (later bits override earlier ones).
    always_comb begin
        chunk_base = int'(ptr) * CHUNK;
        chunk      = s_word[chunk_base +: CHUNK];
        chunk_hit  = |chunk;
        chunk_pos  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) begin
                chunk_pos = POSW'(i);
            end
        end
        hit_index = IDXW'(chunk_base + int'(chunk_pos));
    end

    // Handshake FSM with registered outputs; results are cleared on accept so nothing stale survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_word    <= '0;
            ptr       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_found <= 1'b0;
            out_index <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        s_word    <= in_ones ? ~in_data : in_data;
                        ptr       <= PTR_TOP;
                        state     <= SCAN;
                        in_ready  <= 1'b0;
                        out_found <= 1'b0;
                        out_index <= '0;
                        out_count <= '0;
                    end
                end
                SCAN: begin
                    if (chunk_hit) begin
                        out_found <= 1'b1;
                        out_index <= hit_index;
                        out_count <= CNT_TOP - {1'b0, hit_index};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (ptr == '0) begin
                        out_found <= 1'b0;
                        out_index <= '0;
                        out_count <= CNT_ALL;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ptr <= ptr - 1'b1;
                    end
                end
                DONE: begin
                    // in_ready only rises once back in IDLE, so no same-cycle accept.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/leading_bit_scanner.md
Name: leading_bit_scanner

Overview:
- Multi-cycle, parametrised leading-one/leading-zero scanner for the ALU, backing CLZ/CLO and normalisation-style MSB lookups.
- Scans a WIDTH-bit operand from the top, CHUNK bits per cycle, and terminates early on the first hit.
- Reports the bit index found, the leading count, and an explicit not-found flag.
- Sits beside the ALU datapath behind a valid/ready handshake so the controller can stall on it.

Parameters:
- WIDTH, 32, operand width; power of two, at least 2.
- CHUNK, 8, bits examined per scan cycle; power of two, at most WIDTH, divides WIDTH.
- IDXW, $clog2(WIDTH), width of the bit-index output (derived; do not override).
- NCHUNK, WIDTH/CHUNK, number of chunks (derived).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  operand.
- in_ones  in  1  1 = search for leading ones (CLO); 0 = search for leading zeros (CLZ/MSB).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- out_found  out  1  a target bit was found.
- out_index  out  IDXW  index of the most significant set bit of the searched word.
- out_count  out  IDXW+1  leading-run length, 0..WIDTH.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, in_ready=1, out_valid=0, out_found=0, out_index=0, out_count=0, internal operand and chunk pointer cleared.
- Reset mid-operation: takes effect at the next edge and discards any in-flight scan or unconsumed result.
- Searched word S = in_ones ? ~in_data : in_data, latched at accept. Later in_data/in_ones changes are ignored.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept on in_valid & in_ready; latch S; pointer=NCHUNK-1; go to SCAN.
- State SCAN:
  - in_ready=0.
  - Each cycle, examine S[ptr*CHUNK +: CHUNK].
  - Any bit set: out_index = ptr*CHUNK + position of the highest set bit in the chunk; out_found=1; go to DONE.
  - Chunk zero and ptr==0: out_found=0, out_index=0; go to DONE.
  - Otherwise ptr decrements by 1.
- State DONE:
  - out_valid=1, in_ready=0.
  - Outputs are stable until out_ready is sampled high. On that edge go to IDLE and drop out_valid.
  - No same-cycle accept of a new operand; in_ready rises in IDLE on the following cycle.
- out_count = out_found ? (WIDTH-1-out_index) : WIDTH. Compute in IDXW+1 bits, with no truncation at WIDTH.
- Latency, with accept at edge T and k = number of chunks examined (1..NCHUNK): out_valid is high from cycle T+k+1. Throughput is one result per k+2 cycles with out_ready tied high.
- Priority inside a chunk is strictly MSB-first. Every bit position 0..WIDTH-1 is reachable; no index is skipped or aliased.
- Not-found case always yields defined outputs (found=0, index=0, count=WIDTH). Outputs never hold stale values from a previous operand.
- in_valid while busy is ignored; the operand is not queued.
- CHUNK==WIDTH degenerates to a fixed 2-cycle latency (one SCAN cycle).

Test Plan:
- WIDTH=32, CHUNK=8. in_data=0x8000_0000, in_ones=0 -> out_valid 2 cycles after accept, found=1, index=31, count=0.
- in_data=0x0400_0000, in_ones=0 -> index=26, count=5, latency 2. Then in_data=0x0200_0000 -> index=25, count=6. Checks adjacent bits are not aliased.
- in_data=0x0000_0001, in_ones=0 -> 4 scan cycles, out_valid at T+5, index=0, count=31. Then in_data=0x0000_0000 -> found=0, index=0, count=32, latency 5.
- in_ones=1: in_data=0xFFFF_F000 -> index=11, count=20. in_data=0xFFFF_FFFF -> found=0, count=32. in_data=0x7FFF_FFFF -> count=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a changing in_data. Outputs stay stable and in_ready stays 0. On out_ready=1, the next cycle shows in_ready=1 and the new operand is accepted.
- Assert reset during SCAN and again in DONE: on the next cycle out_valid=0, in_ready=1, all outputs 0. Repeat the exhaustive one-hot sweep (32 operands × both modes) against a reference model at CHUNK=1, 4, 32.
